// File: rtl/ifns_22di_pkg.sv
// Shared IFNS definitions: widths, Fibonacci bit weights and decoder states.
package ifns_22di_pkg;

    localparam int CW_W  = 31;
    localparam int V_W   = 22;
    localparam int ACC_W = 23;

    localparam logic [ACC_W-1:0] V_MAX = 23'd4194303;

    // Weight of each codeword bit, index 0 = d1 ... index 30 = d31 (d31 carries F32).
    localparam logic [ACC_W-1:0] FIB_W [0:CW_W-1] = '{
        23'd1,      23'd1,      23'd2,      23'd3,      23'd5,
        23'd8,      23'd13,     23'd21,     23'd34,     23'd55,
        23'd89,     23'd144,    23'd233,    23'd377,    23'd610,
        23'd987,    23'd1597,   23'd2584,   23'd4181,   23'd6765,
        23'd10946,  23'd17711,  23'd28657,  23'd46368,  23'd75025,
        23'd121393, 23'd196418, 23'd317811, 23'd514229, 23'd832040,
        23'd2178309
    };

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/ifns_lane_sum.sv
// Weighted sum of one group of codeword bits, the first bit of the group being the most significant.
module ifns_lane_sum
    import ifns_22di_pkg::*;
#(
    parameter int LANES = 1,
    parameter int GRP_W = 5
) (
    input  logic [LANES-1:0] bits_i,
    input  logic [GRP_W-1:0] grp_i,
    output logic [ACC_W-1:0] sum_o
);

    int         idx;
    logic [4:0] idx5;

    // Add the weight of every set bit; positions past d1 in a partial last group count as zero.
    always_comb begin
        sum_o = '0;
        idx   = 0;
        idx5  = '0;
        for (int k = 0; k < LANES; k++) begin
            idx  = (CW_W - 1) - int'(grp_i) * LANES - k;
            idx5 = idx[4:0];
            if (bits_i[LANES-1-k] && (idx >= 0)) begin
                sum_o = sum_o + FIB_W[idx5];
            end
        end
    end

endmodule

// File: rtl/decoder_ifns_22di_seq.sv
// Sequential IFNS decoder: folds a 31-bit Fibonacci codeword into a 22-bit value, LANES bits per cycle.
module decoder_ifns_22di_seq
    import ifns_22di_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW_W-1:0] cw,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [V_W-1:0]  v,
    output logic            ovf
);

    localparam int N_GRP = (CW_W + LANES - 1) / LANES;
    localparam int GRP_W = 5;

    state_e            state_q, state_d;
    logic [CW_W-1:0]   sr_q, sr_d;
    logic [GRP_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  laneSum;

    ifns_lane_sum #(
        .LANES (LANES),
        .GRP_W (GRP_W)
    ) u_lane_sum (
        .bits_i (sr_q[CW_W-1 -: LANES]),
        .grp_i  (cnt_q),
        .sum_o  (laneSum)
    );

    // State, shift register, group counter and accumulator; reset drops any in-flight codeword.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Accept in IDLE, consume one group per BUSY cycle MSB-first, hold the result in DONE.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = cw;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_q + laneSum;
                sr_d  = sr_q << LANES;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GRP_W'(N_GRP - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and result outputs; the result is only presented while DONE.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        v         = out_valid ? acc_q[V_W-1:0] : '0;
        ovf       = out_valid && (acc_q > V_MAX);
    end

endmodule

// File: tb/tb_decoder_ifns_22di_seq.sv
// Scoreboard bench for the IFNS decoder at LANES = 1, 4 and 31.
module tb_decoder_ifns_22di_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid  [3];
    logic [30:0] cwIn     [3];
    logic        outReady [3];
    logic        inReady  [3];
    logic        outValid [3];
    logic [21:0] vOut     [3];
    logic        ovfOut   [3];

    typedef struct {
        int          dut;
        logic [21:0] v;
        logic        ovf;
        int          acceptCycle;
        int          lat;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   doneCount [3] = '{0, 0, 0};
    bit   prevValid [3] = '{0, 0, 0};
    int   nGrp      [3] = '{31, 8, 1};
    int   lastAccept = 0;
    bit   rndReady = 0;
    int   rndDut = 0;
    int   fibW [31];

    decoder_ifns_22di_seq #(.LANES(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]), .cw(cwIn[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .v(vOut[0]), .ovf(ovfOut[0]));

    decoder_ifns_22di_seq #(.LANES(4)) u_dut_l4 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]), .cw(cwIn[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .v(vOut[1]), .ovf(ovfOut[1]));

    decoder_ifns_22di_seq #(.LANES(31)) u_dut_l31 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]), .cw(cwIn[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .v(vOut[2]), .ovf(ovfOut[2]));

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure latency and throughput.
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: compares every presented result with the scoreboard head, pops on handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (outValid[d]) begin
                if (expQ.size() == 0 || expQ[0].dut != d) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_out_valid dut=%0d got v=%0d ovf=%0b required no output",
                             d, vOut[d], ovfOut[d]);
                end else begin
                    if (!prevValid[d]) begin
                        checks++;
                        if (cycle - expQ[0].acceptCycle != expQ[0].lat) begin
                            failures++;
                            $display("[TB] FAIL latency dut=%0d got %0d required %0d",
                                     d, cycle - expQ[0].acceptCycle, expQ[0].lat);
                        end
                    end
                    checks++;
                    if (vOut[d] !== expQ[0].v || ovfOut[d] !== expQ[0].ovf) begin
                        failures++;
                        $display("[TB] FAIL result dut=%0d got v=%0d ovf=%0b required v=%0d ovf=%0b",
                                 d, vOut[d], ovfOut[d], expQ[0].v, expQ[0].ovf);
                    end
                    if (outReady[d]) begin
                        void'(expQ.pop_front());
                        doneCount[d]++;
                    end
                end
            end
            prevValid[d] = outValid[d];
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    // Advance to just after the next rising edge; optionally randomise one out_ready.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rndReady) outReady[rndDut] = 1'($urandom_range(0, 1));
    endtask

    // Present one codeword, wait for acceptance and optionally push its expected result.
    task automatic applyStimulus(input int d, input logic [30:0] c, input logic [21:0] expV,
                                 input logic expOvf, input bit push);
        int   guard;
        exp_t e;
        inValid[d] = 1'b1;
        cwIn[d]    = c;
        guard      = 0;
        @(negedge clk);
        while (!inReady[d] && guard < 200) begin
            tick();
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            tick();
            inValid[d] = 1'b0;
            return;
        end
        tick();
        inValid[d] = 1'b0;
        lastAccept = cycle;
        if (push) begin
            e.dut         = d;
            e.v           = expV;
            e.ovf         = expOvf;
            e.acceptCycle = cycle;
            e.lat         = nGrp[d];
            expQ.push_back(e);
        end
    endtask

    // Wait until the scoreboard is drained; the decoder is back in IDLE on return.
    task automatic waitDone();
        int guard;
        guard = 0;
        while (expQ.size() != 0 && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) begin
            checkOutput("result_timeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            inValid[d]  = 1'b0;
            cwIn[d]     = '0;
            outReady[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(inReady[0]), 32'd0);
        checkOutput("reset_out_valid", 32'(outValid[0]), 32'd0);
        checkOutput("reset_v", 32'(vOut[0]), 32'd0);
        checkOutput("reset_ovf", 32'(ovfOut[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) checkOutput("post_reset_in_ready", 32'(inReady[d]), 32'd1);
        tick();
    endtask

    function automatic logic [30:0] encodeFib(input int val);
        int          rem;
        logic [30:0] c;
        rem = val;
        c   = '0;
        for (int k = 30; k >= 0; k--) begin
            if (fibW[k] <= rem) begin
                c[k] = 1'b1;
                rem  = rem - fibW[k];
            end
        end
        return c;
    endfunction

    logic [30:0] tblCw  [8] = '{31'h40000000, 31'h00000003, 31'h7FFFFFFF, 31'h60000000,
                                31'h7DAF6BDF, 31'h7DAF6BDE, 31'h00000001, 31'h20000000};
    logic [21:0] tblV   [8] = '{22'd2178309, 22'd2, 22'd162313, 22'd3010349,
                                22'd0, 22'd4194303, 22'd1, 22'd832040};
    logic        tblOvf [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Main directed sequence.
    initial begin
        int doneBefore;
        int firstAccept;
        int guard;
        int val;

        fibW[0] = 1;
        fibW[1] = 1;
        for (int k = 2; k < 30; k++) fibW[k] = fibW[k-1] + fibW[k-2];
        fibW[30] = fibW[29] + fibW[28] + fibW[29];

        applyReset();

        // All-zero codeword on the single-lane decoder.
        applyStimulus(0, 31'h0, 22'd0, 1'b0, 1'b1);
        waitDone();

        // Reset in the middle of BUSY discards the codeword.
        applyStimulus(0, 31'h7FFFFFFF, 22'd0, 1'b0, 1'b0);
        repeat (10) tick();
        checkOutput("busy_in_ready", 32'(inReady[0]), 32'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("midbusy_rst_out_valid", 32'(outValid[0]), 32'd0);
        checkOutput("midbusy_rst_in_ready", 32'(inReady[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        checkOutput("midbusy_idle_in_ready", 32'(inReady[0]), 32'd1);
        doneBefore = doneCount[0];
        repeat (40) tick();
        checkOutput("midbusy_no_output", 32'(doneCount[0] - doneBefore), 32'd0);

        // Directed table on every lane width.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) begin
                applyStimulus(d, tblCw[i], tblV[i], tblOvf[i], 1'b1);
                waitDone();
            end
        end

        // Throughput with out_ready held high: accepts are N+2 cycles apart.
        for (int d = 0; d < 3; d++) begin
            applyStimulus(d, 31'h00000003, 22'd2, 1'b0, 1'b1);
            firstAccept = lastAccept;
            waitDone();
            applyStimulus(d, 31'h40000000, 22'd2178309, 1'b0, 1'b1);
            checkOutput("throughput", 32'(lastAccept - firstAccept), 32'(nGrp[d] + 2));
            waitDone();
        end

        // Backpressure: result held, input ignored while stalled.
        outReady[0] = 1'b0;
        applyStimulus(0, 31'h60000000, 22'd3010349, 1'b0, 1'b1);
        guard = 0;
        while (!outValid[0] && guard < 100) begin
            tick();
            guard++;
        end
        checkOutput("stall_reach_done", 32'(outValid[0]), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall_in_ready", 32'(inReady[0]), 32'd0);
            checkOutput("stall_out_valid", 32'(outValid[0]), 32'd1);
            if (i == 3) begin
                inValid[0] = 1'b1;
                cwIn[0]    = 31'h7FFFFFFF;
            end
            if (i == 4) inValid[0] = 1'b0;
        end
        doneBefore  = doneCount[0];
        outReady[0] = 1'b1;
        waitDone();
        repeat (40) tick();
        checkOutput("stall_done_count", 32'(doneCount[0] - doneBefore), 32'd1);
        checkOutput("stall_idle_in_ready", 32'(inReady[0]), 32'd1);

        // Round trip through a greedy Fibonacci encoder with random gaps and backpressure.
        for (int d = 0; d < 3; d++) begin
            rndDut   = d;
            rndReady = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (i == 0) val = 0;
                else if (i == 1) val = 4194303;
                else val = int'($urandom_range(0, 4194303));
                repeat ($urandom_range(0, 3)) tick();
                applyStimulus(d, encodeFib(val), 22'(val), 1'b0, 1'b1);
                waitDone();
            end
            rndReady    = 1'b0;
            outReady[d] = 1'b1;
        end

        repeat (5) tick();
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
